// File: rtl/phase_freq_detector_if.sv
// -----------------------------------------------------------------------------
// phase_freq_detector_if
//   Result bundle produced by phase_freq_detector.
//   master : driven by the detector.
//   slave  : seen by the consumer (loop filter, monitor).
//   Signals:
//     upSig / dnSig : A leads / B leads (decoded from detector state)
//     phaseErr      : signed phase error, CNT_WIDTH bits, held between updates
//     errValid      : one-cycle pulse when phaseErr updates
//     satFlag       : qualifies errValid, magnitude was clipped
//     slipFlag      : qualifies errValid, same input edged twice (cycle slip)
//     errSig        : registered XOR of synchronized inputs (0 unless enabled)
// -----------------------------------------------------------------------------
interface phase_freq_detector_if #(
  parameter int CNT_WIDTH = 8
);
  logic                        upSig;
  logic                        dnSig;
  logic signed [CNT_WIDTH-1:0] phaseErr;
  logic                        errValid;
  logic                        satFlag;
  logic                        slipFlag;
  logic                        errSig;

  modport master (
    output upSig, dnSig, phaseErr, errValid, satFlag, slipFlag, errSig
  );

  modport slave (
    input upSig, dnSig, phaseErr, errValid, satFlag, slipFlag, errSig
  );
endinterface

// File: rtl/phase_freq_detector.sv
// -----------------------------------------------------------------------------
// phase_freq_detector
//   Three-state phase/frequency detector with a signed lead-time counter.
//   Each asynchronous input is synchronized (SYNC_STAGES flops) and then
//   rising-edge detected by one more register, so an edge is flagged
//   SYNC_STAGES+1 cycles after the pin transition. The FSM measures how many
//   cycles one input leads the other and reports the signed result.
//
//   Ports:
//     clk        : single clock, rising edge
//     rst        : synchronous active-high reset
//     inputSigA  : reference input, asynchronous to clk
//     inputSigB  : feedback (DCO) input, asynchronous to clk
//     pfd        : result bundle (phase_freq_detector_if.master)
//
//   Optional feature: define PFD_XOR_EN to drive errSig with the registered
//   XOR of the synchronized inputs (legacy XOR detector output). Without it
//   errSig is tied to 0 and no XOR logic exists.
// -----------------------------------------------------------------------------
module phase_freq_detector #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inputSigA,
  input  logic                          inputSigB,
  phase_freq_detector_if.master         pfd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_LEAD = 2'd1,
    B_LEAD = 2'd2
  } state_t;

  // Largest magnitude representable symmetrically: 2^(CNT_WIDTH-1)-1.
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detectors
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic                   last_a_q, last_b_q;
  logic                   rise_a_q, rise_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      last_a_q <= 1'b0;
      last_b_q <= 1'b0;
      rise_a_q <= 1'b0;
      rise_b_q <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], inputSigA};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], inputSigB};
      last_a_q <= sync_a_q[SYNC_STAGES-1];
      last_b_q <= sync_b_q[SYNC_STAGES-1];
      rise_a_q <= sync_a_q[SYNC_STAGES-1] & ~last_a_q;
      rise_b_q <= sync_b_q[SYNC_STAGES-1] & ~last_b_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and lead counter
  // ---------------------------------------------------------------------------
  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic                        sat_now;
  logic signed [CNT_WIDTH-1:0] err_q, err_d;
  logic                        valid_q, valid_d;
  logic                        sat_q, sat_d;
  logic                        slip_q, slip_d;
  logic                        up_q, dn_q;

  // cnt_q holds the number of completed lead cycles; the closing cycle itself
  // is included by reporting cnt_q+1, clipped at CNT_MAX.
  assign sat_now = (cnt_q == CNT_MAX);
  assign cnt_inc = sat_now ? CNT_MAX : (cnt_q + CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    slip_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_a_q && rise_b_q) begin
          // Coincident edges: zero phase error, no lead state entered.
          valid_d = 1'b1;
          err_d   = '0;
        end else if (rise_a_q) begin
          state_d = A_LEAD;
        end else if (rise_b_q) begin
          state_d = B_LEAD;
        end
      end

      A_LEAD: begin
        cnt_d = cnt_inc;
        if (rise_a_q || rise_b_q) begin
          valid_d = 1'b1;
          err_d   = cnt_inc;
          sat_d   = sat_now;
          cnt_d   = '0;
          if (rise_a_q) begin
            // A edged again: it reopens the measurement. Without a B edge
            // in the same cycle this is a cycle slip.
            slip_d = ~rise_b_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      B_LEAD: begin
        cnt_d = cnt_inc;
        if (rise_a_q || rise_b_q) begin
          valid_d = 1'b1;
          err_d   = -cnt_inc;
          sat_d   = sat_now;
          cnt_d   = '0;
          if (rise_b_q) begin
            slip_d = ~rise_a_q;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      slip_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      slip_q  <= slip_d;
      // Direction outputs are registered copies of the state so they are
      // glitch-free flop outputs that track state_q exactly.
      up_q    <= (state_d == A_LEAD);
      dn_q    <= (state_d == B_LEAD);
    end
  end

  assign pfd.upSig    = up_q;
  assign pfd.dnSig    = dn_q;
  assign pfd.phaseErr = err_q;
  assign pfd.errValid = valid_q;
  assign pfd.satFlag  = sat_q;
  assign pfd.slipFlag = slip_q;

  // ---------------------------------------------------------------------------
  // Legacy XOR detector output
  // ---------------------------------------------------------------------------
`ifdef PFD_XOR_EN
  logic err_sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sig_q <= 1'b0;
    end else begin
      err_sig_q <= sync_a_q[SYNC_STAGES-1] ^ sync_b_q[SYNC_STAGES-1];
    end
  end

  assign pfd.errSig = err_sig_q;
`else
  assign pfd.errSig = 1'b0;
`endif

endmodule

// File: tb/tb_phase_freq_detector.sv
// -----------------------------------------------------------------------------
// tb_phase_freq_detector
//   Two detectors (CNT_WIDTH 8 and 4) share the same inputs. Stimulus pushes
//   the expected result for each width into a per-DUT queue; a monitor pops
//   and compares whenever errValid is seen.
// -----------------------------------------------------------------------------
module tb_phase_freq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_a = 1'b0;
  logic sig_b = 1'b0;

  always #5 clk = ~clk;

  phase_freq_detector_if #(.CNT_WIDTH(8)) if8 ();
  phase_freq_detector_if #(.CNT_WIDTH(4)) if4 ();

  phase_freq_detector #(.CNT_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .inputSigA (sig_a),
    .inputSigB (sig_b),
    .pfd       (if8.master)
  );

  phase_freq_detector #(.CNT_WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .inputSigA (sig_a),
    .inputSigB (sig_b),
    .pfd       (if4.master)
  );

  typedef struct {
    int err;
    bit sat;
    bit slip;
    int up;
    int dn;
  } exp_t;

  exp_t exp_q[2][$];
  int   up_acc[2];
  int   dn_acc[2];
  int   checks = 0;
  int   errors = 0;

  // Expected errSig: the input XOR delayed by SYNC_STAGES+1 = 3 cycles.
  logic [2:0] xor_hist;
  always @(posedge clk) begin
    if (rst) xor_hist <= '0;
    else     xor_hist <= {xor_hist[1:0], sig_a ^ sig_b};
  end

  // k > 0: A leads by k cycles; k < 0: B leads by -k cycles; 0: coincident.
  function automatic void push_exp(int k, bit slip, int up, int dn);
    for (int idx = 0; idx < 2; idx++) begin
      exp_t e;
      int   w   = (idx == 0) ? 8 : 4;
      int   lim = (1 << (w - 1)) - 1;
      int   mag = (k < 0) ? -k : k;
      e.sat  = (mag > lim);
      if (mag > lim) mag = lim;
      e.err  = (k < 0) ? -mag : mag;
      e.slip = slip;
      e.up   = up;
      e.dn   = dn;
      exp_q[idx].push_back(e);
    end
  endfunction

  task automatic mon(input int idx, input logic ev, input logic signed [15:0] pe,
                     input logic sat, input logic slip, input logic up,
                     input logic dn, input logic es, input logic es_exp);
    exp_t e;
    checks++;
    if (up & dn) begin
      errors++;
      $display("FAIL up_dn_exclusive dut%0d: up=%b dn=%b, required not both high", idx, up, dn);
    end
    checks++;
    if (!ev && (sat || slip)) begin
      errors++;
      $display("FAIL flags_unqualified dut%0d: sat=%b slip=%b without errValid, required 0", idx, sat, slip);
    end
    checks++;
    if (es !== es_exp) begin
      errors++;
      $display("FAIL errSig dut%0d: got %b, required %b", idx, es, es_exp);
    end
    if (ev) begin
      checks++;
      if (exp_q[idx].size() == 0) begin
        errors++;
        $display("FAIL unexpected_errValid dut%0d: phaseErr=%0d with nothing expected", idx, int'(pe));
      end else begin
        e = exp_q[idx].pop_front();
        if (int'(pe) != e.err || sat !== e.sat || slip !== e.slip ||
            up_acc[idx] != e.up || dn_acc[idx] != e.dn) begin
          errors++;
          $display("FAIL result dut%0d: got err=%0d sat=%b slip=%b up=%0d dn=%0d, required err=%0d sat=%b slip=%b up=%0d dn=%0d",
                   idx, int'(pe), sat, slip, up_acc[idx], dn_acc[idx],
                   e.err, e.sat, e.slip, e.up, e.dn);
        end else begin
          $display("txn dut%0d: phaseErr=%0d sat=%b slip=%b up=%0d dn=%0d ok",
                   idx, int'(pe), sat, slip, up_acc[idx], dn_acc[idx]);
        end
      end
      up_acc[idx] = 0;
      dn_acc[idx] = 0;
    end
    up_acc[idx] += int'(up);
    dn_acc[idx] += int'(dn);
  endtask

  logic es_exp;
`ifdef PFD_XOR_EN
  assign es_exp = xor_hist[2];
`else
  assign es_exp = 1'b0;
`endif

  always @(negedge clk) begin
    if (rst) begin
      up_acc[0] = 0; up_acc[1] = 0;
      dn_acc[0] = 0; dn_acc[1] = 0;
    end else begin
      mon(0, if8.errValid, if8.phaseErr, if8.satFlag, if8.slipFlag,
          if8.upSig, if8.dnSig, if8.errSig, es_exp);
      mon(1, if4.errValid, if4.phaseErr, if4.satFlag, if4.slipFlag,
          if4.upSig, if4.dnSig, if4.errSig, es_exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    checks++;
    if ({if8.upSig, if8.dnSig, if8.phaseErr, if8.errValid, if8.satFlag,
         if8.slipFlag, if8.errSig} !== '0) begin
      errors++;
      $display("FAIL %s dut0: up=%b dn=%b err=%0d v=%b sat=%b slip=%b es=%b, required all 0",
               tag, if8.upSig, if8.dnSig, if8.phaseErr, if8.errValid,
               if8.satFlag, if8.slipFlag, if8.errSig);
    end
    checks++;
    if ({if4.upSig, if4.dnSig, if4.phaseErr, if4.errValid, if4.satFlag,
         if4.slipFlag, if4.errSig} !== '0) begin
      errors++;
      $display("FAIL %s dut1: up=%b dn=%b err=%0d v=%b sat=%b slip=%b es=%b, required all 0",
               tag, if4.upSig, if4.dnSig, if4.phaseErr, if4.errValid,
               if4.satFlag, if4.slipFlag, if4.errSig);
    end
  endtask

  task automatic pair(input int k);
    push_exp(k, 1'b0, (k > 0) ? k : 0, (k < 0) ? -k : 0);
    if (k == 0) begin
      sig_a = 1'b1; sig_b = 1'b1;
    end else if (k > 0) begin
      sig_a = 1'b1; cyc(k); sig_b = 1'b1;
    end else begin
      sig_b = 1'b1; cyc(-k); sig_a = 1'b1;
    end
    cyc(8);
    sig_a = 1'b0; sig_b = 1'b0;
    cyc(8);
  endtask

  initial begin
    rst = 1'b1;
    cyc(3);
    chk_zero("reset_state");
    rst = 1'b0;
    cyc(4);

    // Directed leads/lags; the 4-bit DUT clips at +/-7.
    pair(5);
    pair(-3);
    pair(0);
    pair(20);
    pair(-20);
    pair(7);
    pair(8);
    pair(-8);

    // Cycle slip: A period 10, no B, then B closes 3 cycles after the last A.
    for (int i = 0; i < 3; i++) push_exp(10, 1'b1, 10, 0);
    push_exp(3, 1'b0, 3, 0);
    sig_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(5); sig_a = 1'b0;
      cyc(5); sig_a = 1'b1;
    end
    cyc(3); sig_b = 1'b1;
    cyc(8); sig_a = 1'b0; sig_b = 1'b0;
    cyc(8);

    // In A_LEAD, A and B edge together: B closes (+4), A reopens, then B
    // closes the new measurement 3 cycles later.
    push_exp(4, 1'b0, 4, 0);
    push_exp(3, 1'b0, 3, 0);
    sig_a = 1'b1;
    cyc(2); sig_a = 1'b0;
    cyc(2); sig_a = 1'b1; sig_b = 1'b1;
    cyc(1); sig_b = 1'b0;
    cyc(2); sig_b = 1'b1;
    cyc(8); sig_a = 1'b0; sig_b = 1'b0;
    cyc(8);

    // Reset in the middle of an A_LEAD measurement: nothing is emitted.
    sig_a = 1'b1;
    cyc(8);
    rst = 1'b1; sig_a = 1'b0;
    cyc(1);
    chk_zero("reset_mid_measure");
    cyc(6);
    rst = 1'b0;
    cyc(4);
    chk_zero("after_reset_release");
    pair(2);

    cyc(20);
    for (int idx = 0; idx < 2; idx++) begin
      checks++;
      if (exp_q[idx].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d results never arrived, required 0 pending",
                 idx, exp_q[idx].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
